// File: rtl/sd_sector_client.sv
// sd_sector_client: per-drive requester that turns host sector reads/writes into the sd_card start/done handshake.
// Optional SD_SECTOR_CLIENT_BYTECOUNT_EN faults reads whose outen strobe count is not exactly 512.
module sd_sector_client #(
  parameter int DRIVE    = 0,
  parameter int TMO_BITS = 24
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_sector,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        media_changed,
  input  logic [8:0]  buf_addr,
  input  logic        buf_we,
  input  logic [7:0]  buf_wdata,
  output logic [7:0]  buf_rdata,
  output logic [7:0]  rstart,
  output logic [7:0]  wstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic [7:0]  inbyte,
  input  logic [7:0]  image_mounted,
  input  logic [31:0] image_size
);

  localparam logic [2:0] DRV = DRIVE[2:0];

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, FINISH, GAP} state_t;

  state_t              state, state_next;
  logic                wr_q, err_q, gap_q;
  logic [31:0]         sector_q;
  logic [TMO_BITS-1:0] tmo_cnt;
  logic                accept, issue, range_bad, tmo_hit, rd_fault, rd_capture;
  logic [7:0]          mem [0:511];
  logic                unused_mounts;

  assign unused_mounts = ^image_mounted;
  assign range_bad     = (image_size == 32'd0) || (req_sector >= {9'd0, image_size[31:9]});
  assign tmo_hit       = &tmo_cnt;
  assign rd_capture    = outen && (state == WAIT_DONE) && !wr_q;

`ifdef SD_SECTOR_CLIENT_BYTECOUNT_EN
  logic [9:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (!rstn)
      byte_cnt <= '0;
    else if (issue)
      byte_cnt <= '0;
    else if (rd_capture)
      byte_cnt <= byte_cnt + 10'd1;
  end

  assign rd_fault = !wr_q && (byte_cnt != 10'd512);
`else
  assign rd_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = range_bad ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (!rbusy) begin
          issue      = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (rdone || tmo_hit)
          state_next = FINISH;
      end
      FINISH:  state_next = GAP;
      GAP: begin
        if (gap_q)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Timeout counter is loaded with 1 on issue so the start bit stays high for 2^TMO_BITS-1 cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      gap_q         <= 1'b0;
      sector_q      <= '0;
      rsector       <= '0;
      tmo_cnt       <= '0;
      media_changed <= 1'b0;
    end else begin
      if (accept) begin
        wr_q     <= req_write;
        sector_q <= req_sector;
        err_q    <= range_bad;
      end
      if (issue) begin
        rsector <= sector_q;
        tmo_cnt <= TMO_BITS'(1);
      end else if (state == WAIT_DONE) begin
        tmo_cnt <= tmo_cnt + TMO_BITS'(1);
        if (rdone)
          err_q <= rd_fault;
        else if (tmo_hit)
          err_q <= 1'b1;
      end
      gap_q <= (state == GAP) && !gap_q;
      if (image_mounted[DRV])
        media_changed <= 1'b1;
      else if (accept)
        media_changed <= 1'b0;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign error     = done && err_q;

  // Start bits are gated by rstn so they fall in the same cycle reset is applied.
  always_comb begin
    rstart      = '0;
    wstart      = '0;
    rstart[DRV] = rstn && (state == WAIT_DONE) && !wr_q;
    wstart[DRV] = rstn && (state == WAIT_DONE) && wr_q;
  end

  always_ff @(posedge clk) begin
    if (buf_we && !busy)
      mem[buf_addr] <= buf_wdata;
    if (rd_capture)
      mem[outaddr] <= outbyte;
    buf_rdata <= mem[buf_addr];
    inbyte    <= mem[outaddr];
  end

endmodule

// File: tb/tb_sd_sector_client.sv
// tb_sd_sector_client: randomized scoreboard bench for sd_sector_client with an sd_card responder model.
// Expectations for error flags follow SD_SECTOR_CLIENT_BYTECOUNT_EN when it is defined.
module tb_sd_sector_client;

`ifdef SD_SECTOR_CLIENT_BYTECOUNT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  localparam int TMO = 10;
  localparam logic [1:0] M_NORMAL = 2'd0, M_SHORT = 2'd1, M_NONE = 2'd2, M_PATTERN = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [31:0] sector;
    logic [1:0]  mode;
  } iss_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_sector = '0;
  logic busy, done, error, media_changed;
  logic [8:0] buf_addr = '0;
  logic buf_we = 1'b0;
  logic [7:0] buf_wdata = '0, buf_rdata;
  logic [7:0] rstart, wstart;
  logic [31:0] rsector;
  logic rbusy = 1'b0, rdone = 1'b0, outen = 1'b0;
  logic [8:0] outaddr = '0;
  logic [7:0] outbyte = '0, inbyte;
  logic [7:0] image_mounted = '0;
  logic [31:0] image_size = 32'h0001_0000;

  int checks = 0, errors = 0;
  logic [7:0] model_buf [512];
  bit exp_q[$];
  iss_t iss_q[$];
  logic [31:0] last_sector = '0;
  bit media_exp = 1'b0, rst_abort = 1'b0;
  bit rd_new_valid = 1'b0;
  logic [7:0] rd_new_exp = '0;

  sd_sector_client #(.DRIVE(2), .TMO_BITS(TMO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_sector(req_sector), .busy(busy), .done(done),
    .error(error), .media_changed(media_changed), .buf_addr(buf_addr),
    .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .rstart(rstart), .wstart(wstart), .rsector(rsector), .rbusy(rbusy),
    .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .inbyte(inbyte), .image_mounted(image_mounted), .image_size(image_size)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int cyc = 0;
    do begin
      tick();
      cyc++;
    end while (req_ready !== 1'b1 && cyc < 4000);
    checkOutput("idle_reached", req_ready, 1);
  endtask

  task automatic hostWrite(input logic [8:0] a, input logic [7:0] d);
    buf_addr  = a;
    buf_wdata = d;
    buf_we    = 1'b1;
    model_buf[a] = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic hostRead(input logic [8:0] a);
    buf_addr     = a;
    rd_new_exp   = model_buf[a];
    rd_new_valid = 1'b1;
    tick();
  endtask

  // Expected outcome comes from the request rules: range, timeout, and the optional byte count.
  task automatic applyStimulus(input bit wr, input logic [31:0] sec, input logic [1:0] mode, input bit mount_same);
    bit bad;
    iss_t e;
    bad = (image_size == 0) || (sec >= image_size / 512);
    exp_q.push_back(bad || mode == M_NONE || (BC && !wr && mode == M_SHORT));
    if (!bad) begin
      e.wr = wr; e.sector = sec; e.mode = mode;
      iss_q.push_back(e);
    end
    req_valid     = 1'b1;
    req_write     = wr;
    req_sector    = sec;
    image_mounted = mount_same ? 8'h04 : 8'h00;
    tick();
    req_valid     = 1'b0;
    image_mounted = 8'h00;
    media_exp     = mount_same;
    checkOutput("accept_busy", busy, 1);
    checkOutput("media_after_accept", media_changed, media_exp);
  endtask

  // Done monitor: pops the expected error flag and checks the two-cycle gap that follows.
  initial begin : done_mon
    bit e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        checkOutput("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("done_error", error, e);
        end
        checkOutput("rsector_hold", rsector, last_sector);
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          if (k < 3) begin
            checkOutput("gap_not_ready", req_ready, 0);
            checkOutput("gap_start_low", {rstart, wstart}, 0);
            checkOutput("done_one_cycle", done, 0);
          end else begin
            checkOutput("ready_after_gap", req_ready, 1);
          end
        end
      end
    end
  end

  initial begin : rd_mon
    bit pend = 1'b0;
    logic [7:0] pend_exp = '0;
    forever begin
      @(negedge clk);
      if (pend) checkOutput("buf_rdata", buf_rdata, pend_exp);
      pend         = rd_new_valid;
      pend_exp     = rd_new_exp;
      rd_new_valid = 1'b0;
    end
  end

  // sd_card responder: checks each issued start, then streams, consumes, or ignores the request.
  initial begin : sd_model
    iss_t e;
    bit is_wr;
    int hi;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if ((rstart | wstart) != 8'h00) begin
        is_wr = wstart[2];
        checkOutput("start_bits", {rstart, wstart}, is_wr ? 16'h0004 : 16'h0400);
        checkOutput("issue_expected", iss_q.size() > 0, 1);
        e = '0;
        if (iss_q.size() > 0) begin
          e = iss_q.pop_front();
          checkOutput("start_kind", is_wr, e.wr);
          checkOutput("rsector", rsector, e.sector);
          last_sector = e.sector;
        end
        if (e.mode == M_NONE) begin
          hi = 1;
          for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if ((rstart | wstart) == 8'h00) break;
            hi++;
          end
          if (!rst_abort) checkOutput("tmo_high_cycles", hi, (1 << TMO) - 1);
        end else if (is_wr) begin
          @(posedge clk); #1 outaddr = 9'd0;
          for (int a = 0; a < 512; a++) begin
            @(posedge clk); #1;
            if (a < 511) outaddr = 9'(a + 1);
            @(negedge clk);
            checkOutput("inbyte", inbyte, model_buf[a]);
          end
          @(posedge clk); #1 rdone = 1'b1;
          @(posedge clk); #1 rdone = 1'b0;
        end else begin
          for (int a = 0; a < ((e.mode == M_SHORT) ? 511 : 512); a++) begin
            @(posedge clk); #1;
            if (a % 16 == 0 && $urandom_range(0, 3) == 0) begin
              outen = 1'b0;
              @(posedge clk); #1;
            end
            b = (e.mode == M_PATTERN) ? 8'(a) : 8'($urandom);
            outen = 1'b1; outaddr = 9'(a); outbyte = b;
            model_buf[a] = b;
          end
          @(posedge clk); #1 outen = 1'b0; rdone = 1'b1;
          @(posedge clk); #1 rdone = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [31:0] sec;
    bit wr;
    for (int i = 0; i < 512; i++) model_buf[i] = 8'h00;
    for (int i = 0; i < 512; i++) hostWrite(9'(i), 8'h00);
    repeat (3) tick();
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_media", media_changed, 0);
    checkOutput("rst_starts", {rstart, wstart}, 0);
    checkOutput("rst_rsector", rsector, 0);
    rstn = 1'b1;
    tick();

    applyStimulus(1'b0, 32'd5, M_PATTERN, 1'b0);
    waitIdle();
    hostRead(9'h1FF);
    hostRead(9'h080);
    for (int i = 0; i < 8; i++) hostRead(9'($urandom));

    for (int i = 0; i < 512; i++) hostWrite(9'(i), 8'(i) ^ 8'hA5);
    applyStimulus(1'b1, 32'd7, M_NORMAL, 1'b0);
    buf_addr = 9'd0; buf_wdata = ~model_buf[0]; buf_we = 1'b1;
    tick();
    buf_we = 1'b0;
    waitIdle();

    applyStimulus(1'b0, 32'd128, M_NORMAL, 1'b0);
    checkOutput("range_done_now", done, 1);
    waitIdle();
    image_size = 32'd0;
    applyStimulus(1'b0, 32'd0, M_NORMAL, 1'b0);
    waitIdle();
    image_size = 32'h0001_0000;

    rbusy = 1'b1;
    applyStimulus(1'b0, 32'd20, M_NORMAL, 1'b0);
    repeat (4) begin
      tick();
      checkOutput("issue_start_low", {rstart, wstart}, 0);
    end
    rbusy = 1'b0;
    checkOutput("start_before_edge", rstart, 8'h00);
    tick();
    checkOutput("start_after_rbusy", rstart, 8'h04);
    repeat (40) tick();
    image_mounted = 8'h08;
    tick();
    image_mounted = 8'h00;
    checkOutput("media_other_drive", media_changed, media_exp);
    image_mounted = 8'h04;
    tick();
    image_mounted = 8'h00;
    media_exp = 1'b1;
    checkOutput("media_set", media_changed, media_exp);
    waitIdle();
    checkOutput("media_sticky", media_changed, media_exp);
    applyStimulus(1'b1, 32'd3, M_NORMAL, 1'b0);
    waitIdle();
    applyStimulus(1'b0, 32'd4, M_NORMAL, 1'b1);
    waitIdle();

    applyStimulus(1'b0, 32'd9, M_NONE, 1'b0);
    waitIdle();
    applyStimulus(1'b0, 32'd11, M_SHORT, 1'b0);
    waitIdle();
    hostRead(9'h1FF);
    hostRead(9'h1FE);

    for (int n = 0; n < 10; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sec = 32'($urandom_range(0, 140));
      if (wr) for (int i = 0; i < 16; i++) hostWrite(9'($urandom), 8'($urandom));
      applyStimulus(wr, sec, (!wr && $urandom_range(0, 5) == 0) ? M_SHORT : M_NORMAL, 1'b0);
      waitIdle();
      for (int i = 0; i < 6; i++) hostRead(9'($urandom));
    end

    rst_abort = 1'b1;
    applyStimulus(1'b0, 32'd9, M_NONE, 1'b0);
    repeat (20) tick();
    checkOutput("start_before_reset", rstart, 8'h04);
    rstn = 1'b0;
    #1;
    checkOutput("start_drop_in_reset", {rstart, wstart}, 0);
    tick();
    exp_q.delete();
    media_exp   = 1'b0;
    last_sector = '0;
    checkOutput("no_done_in_reset", done, 0);
    rstn = 1'b1;
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsector", rsector, 0);
    rst_abort = 1'b0;
    applyStimulus(1'b0, 32'd2, M_NORMAL, 1'b0);
    waitIdle();
    hostRead(9'd0);

    repeat (10) tick();
    checkOutput("exp_q_drained", exp_q.size(), 0);
    checkOutput("iss_q_drained", iss_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
